// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator on clk_sys with a pixel clock-enable.
// Sync offsets are latched at frame wrap so image shifts never glitch.
module video_timing_gen #(
  parameter int H_TOTAL    = 384,
  parameter int H_ACT_BEG  = 24,
  parameter int H_ACT_END  = 280,
  parameter int H_SYNC_BEG = 304,
  parameter int H_SYNC_LEN = 32,
  parameter int V_TOTAL    = 263,
  parameter int V_ACT_BEG  = 16,
  parameter int V_ACT_END  = 240,
  parameter int V_SYNC_BEG = 244,
  parameter int V_SYNC_LEN = 6,
  parameter int HOFFS_W    = 5,
  parameter int VOFFS_W    = 3,
  parameter int H_STEP     = 2,
  parameter int V_STEP     = 1,
  parameter int SYNC_POL   = 0,
  parameter int RGB_W      = 12
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ce_pix,
  input  logic signed [HOFFS_W-1:0] hoffs,
  input  logic signed [VOFFS_W-1:0] voffs,
  input  logic [RGB_W-1:0]          iRGB,
  output logic [8:0]                hpos,
  output logic [8:0]                vpos,
  output logic                      hblank,
  output logic                      vblank,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      de,
  output logic [RGB_W-1:0]          oRGB,
  output logic                      line_start,
  output logic                      frame_start
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  if (H_ACT_END > H_TOTAL || V_ACT_END > V_TOTAL ||
      H_SYNC_LEN >= H_TOTAL || V_SYNC_LEN >= V_TOTAL) begin : g_geom_err
    $error("video_timing_gen: illegal geometry");
  end

  logic [HW-1:0]             r_hcnt;
  logic [VW-1:0]             r_vcnt;
  logic signed [HOFFS_W-1:0] r_hoffs;
  logic signed [VOFFS_W-1:0] r_voffs;
  logic                      r_hblank, r_vblank, r_de;
  logic                      r_hs, r_vs, r_ls, r_fs;
  logic [RGB_W-1:0]          r_rgb;

  int   w_hc, w_vc, w_hs_beg, w_vs_beg, w_hd, w_vd;
  logic w_hlast, w_vlast, w_hact, w_vact, w_hs, w_vs;

  always_comb begin
    w_hc     = int'(r_hcnt);
    w_vc     = int'(r_vcnt);
    w_hs_beg = H_SYNC_BEG + int'(r_hoffs) * H_STEP;
    w_vs_beg = V_SYNC_BEG + int'(r_voffs) * V_STEP;
    if (w_hs_beg < 0)             w_hs_beg = w_hs_beg + H_TOTAL;
    else if (w_hs_beg >= H_TOTAL) w_hs_beg = w_hs_beg - H_TOTAL;
    if (w_vs_beg < 0)             w_vs_beg = w_vs_beg + V_TOTAL;
    else if (w_vs_beg >= V_TOTAL) w_vs_beg = w_vs_beg - V_TOTAL;
    // distance past sync start, folded so windows may straddle the wrap
    w_hd = w_hc - w_hs_beg;
    if (w_hd < 0) w_hd = w_hd + H_TOTAL;
    w_vd = w_vc - w_vs_beg;
    if (w_vd < 0) w_vd = w_vd + V_TOTAL;
    w_hs    = w_hd < H_SYNC_LEN;
    w_vs    = w_vd < V_SYNC_LEN;
    w_hact  = (w_hc >= H_ACT_BEG) && (w_hc < H_ACT_END);
    w_vact  = (w_vc >= V_ACT_BEG) && (w_vc < V_ACT_END);
    w_hlast = r_hcnt == HW'(H_TOTAL - 1);
    w_vlast = r_vcnt == VW'(V_TOTAL - 1);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_hoffs  <= '0;
      r_voffs  <= '0;
      r_hblank <= 1'b1;
      r_vblank <= 1'b1;
      r_de     <= 1'b0;
      r_rgb    <= '0;
      r_hs     <= 1'b0;
      r_vs     <= 1'b0;
      r_ls     <= 1'b0;
      r_fs     <= 1'b0;
    end else if (ce_pix) begin
      r_hcnt <= w_hlast ? '0 : r_hcnt + 1'b1;
      if (w_hlast) r_vcnt <= w_vlast ? '0 : r_vcnt + 1'b1;
      if (w_hlast && w_vlast) begin
        r_hoffs <= hoffs;
        r_voffs <= voffs;
      end
      r_hblank <= ~w_hact;
      r_vblank <= ~w_vact;
      r_de     <= w_hact & w_vact;
      r_rgb    <= (w_hact & w_vact) ? iRGB : '0;
      r_hs     <= w_hs;
      if (r_hcnt == '0) r_vs <= w_vs;
      r_ls     <= w_hlast;
      r_fs     <= w_hlast & w_vlast;
    end else begin
      r_ls <= 1'b0;
      r_fs <= 1'b0;
    end
  end

  assign hpos        = 9'(w_hc - H_ACT_BEG);
  assign vpos        = 9'(w_vc - V_ACT_BEG);
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign de          = r_de;
  assign oRGB        = r_rgb;
  assign hsync       = (SYNC_POL != 0) ? r_hs : ~r_hs;
  assign vsync       = (SYNC_POL != 0) ? r_vs : ~r_vs;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule
